// File: rtl/axil_sram.sv
// AXI4-Lite single-port SRAM slave with independent read and write FSMs.
// Define AXIL_SRAM_RANGE_CHECK_EN to answer SLVERR for addresses beyond the array.
module axil_sram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_W  = 10
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              awValid,
    output logic              awReady,
    input  logic [ADDR_W-1:0] awAddr,
    input  logic [2:0]        awProt,
    input  logic              wValid,
    output logic              wReady,
    input  logic [DATA_W-1:0] wData,
    input  logic [DATA_W/8-1:0] wStrb,
    output logic              bValid,
    input  logic              bReady,
    output logic [1:0]        bResp,
    input  logic              arValid,
    output logic              arReady,
    input  logic [ADDR_W-1:0] arAddr,
    input  logic [2:0]        arProt,
    output logic              rValid,
    input  logic              rReady,
    output logic [DATA_W-1:0] rData,
    output logic [1:0]        rResp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int L      = $clog2(STRB_W);
    localparam int DEPTH  = 1 << MEM_W;
    localparam int HI_SH  = MEM_W + L;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : gBadDataW
            $error("axil_sram: DATA_W must be 32 or 64");
        end
        if (ADDR_W < MEM_W + L) begin : gBadAddrW
            $error("axil_sram: ADDR_W too small for MEM_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        W_RST,
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wStateT;

    typedef enum logic [1:0] {
        R_RST,
        R_IDLE,
        R_RESP
    } rStateT;

    logic [DATA_W-1:0] mem [DEPTH];

    wStateT wState, wNext;
    rStateT rState, rNext;

    logic              awHs, wHs, arHs;
    logic              commit, latchAw, latchW;
    logic [ADDR_W-1:0] awAddrQ;
    logic [DATA_W-1:0] wDataQ;
    logic [STRB_W-1:0] wStrbQ;
    logic [ADDR_W-1:0] cAddr;
    logic [DATA_W-1:0] cData;
    logic [STRB_W-1:0] cStrb;
    logic [MEM_W-1:0]  wIdx, rIdx;
    logic              cHi, arHi;
    logic              wOor, rOor;
    logic              unusedBits;

    assign awHs = awValid && awReady;
    assign wHs  = wValid && wReady;
    assign arHs = arValid && arReady;

    assign wIdx = cAddr[MEM_W+L-1:L];
    assign rIdx = arAddr[MEM_W+L-1:L];
    assign cHi  = |(cAddr >> HI_SH);
    assign arHi = |(arAddr >> HI_SH);

`ifdef AXIL_SRAM_RANGE_CHECK_EN
    assign wOor       = cHi;
    assign rOor       = arHi;
    assign unusedBits = ^{awProt, arProt};
`else
    assign wOor       = 1'b0;
    assign rOor       = 1'b0;
    assign unusedBits = ^{awProt, arProt, cHi, arHi};
`endif

    // Commit source muxes between the live channel and whichever half was latched.
    always_comb begin
        wNext   = wState;
        commit  = 1'b0;
        latchAw = 1'b0;
        latchW  = 1'b0;
        cAddr   = awAddr;
        cData   = wData;
        cStrb   = wStrb;
        unique case (wState)
            W_RST: wNext = W_IDLE;
            W_IDLE: begin
                if (awHs && wHs) begin
                    commit = 1'b1;
                    wNext  = W_RESP;
                end else if (awHs) begin
                    latchAw = 1'b1;
                    wNext   = W_HAVE_AW;
                end else if (wHs) begin
                    latchW = 1'b1;
                    wNext  = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                cAddr = awAddrQ;
                if (wHs) begin
                    commit = 1'b1;
                    wNext  = W_RESP;
                end
            end
            W_HAVE_W: begin
                cData = wDataQ;
                cStrb = wStrbQ;
                if (awHs) begin
                    commit = 1'b1;
                    wNext  = W_RESP;
                end
            end
            W_RESP: begin
                if (bValid && bReady) begin
                    wNext = W_IDLE;
                end
            end
            default: wNext = W_RST;
        endcase
        if (areset) begin
            wNext   = W_RST;
            commit  = 1'b0;
            latchAw = 1'b0;
            latchW  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wState  <= W_RST;
            awReady <= 1'b0;
            wReady  <= 1'b0;
            bValid  <= 1'b0;
            bResp   <= OKAY;
        end else begin
            wState  <= wNext;
            awReady <= (wNext == W_IDLE) || (wNext == W_HAVE_W);
            wReady  <= (wNext == W_IDLE) || (wNext == W_HAVE_AW);
            bValid  <= (wNext == W_RESP);
            if (commit) begin
                bResp <= wOor ? SLVERR : OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (latchAw) begin
            awAddrQ <= awAddr;
        end
        if (latchW) begin
            wDataQ <= wData;
            wStrbQ <= wStrb;
        end
    end

    // No reset on the array: contents survive areset.
    always_ff @(posedge aclk) begin
        if (commit && !wOor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (cStrb[i]) begin
                    mem[wIdx][8*i +: 8] <= cData[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rNext = rState;
        unique case (rState)
            R_RST: rNext = R_IDLE;
            R_IDLE: begin
                if (arHs) begin
                    rNext = R_RESP;
                end
            end
            R_RESP: begin
                if (rValid && rReady) begin
                    rNext = R_IDLE;
                end
            end
            default: rNext = R_RST;
        endcase
        if (areset) begin
            rNext = R_RST;
        end
    end

    // Array read uses the pre-edge contents, so a same-edge write is not seen.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rState  <= R_RST;
            arReady <= 1'b0;
            rValid  <= 1'b0;
            rData   <= '0;
            rResp   <= OKAY;
        end else begin
            rState  <= rNext;
            arReady <= (rNext == R_IDLE);
            rValid  <= (rNext == R_RESP);
            if (arHs) begin
                rData <= rOor ? '0 : mem[rIdx];
                rResp <= rOor ? SLVERR : OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axil_sram.sv
// Randomized self-checking bench for axil_sram (32-bit and 64-bit builds).
// Expectations follow AXIL_SRAM_RANGE_CHECK_EN when it is defined.
module tb_axil_sram;

`ifdef AXIL_SRAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic aclk = 1'b0;
    logic areset;

    logic        awValid, awReady, wValid, wReady;
    logic        bValid, bReady, arValid, arReady;
    logic        rValid, rReady;
    logic [31:0] awAddr, arAddr, wData, rData;
    logic [3:0]  wStrb;
    logic [1:0]  bResp, rResp;
    logic [2:0]  prot;

    logic        xAwValid, xAwReady, xWValid, xWReady;
    logic        xBValid, xBReady, xArValid, xArReady;
    logic        xRValid, xRReady;
    logic [31:0] xAwAddr, xArAddr;
    logic [63:0] xWData, xRData;
    logic [7:0]  xWStrb;
    logic [1:0]  xBResp, xRResp;

    int checks = 0;
    int errors = 0;

    logic [31:0] refMem [1024];
    logic [63:0] refWide [16];

    always #5 aclk = ~aclk;

    axil_sram dut (
        .aclk(aclk), .areset(areset),
        .awValid(awValid), .awReady(awReady),
        .awAddr(awAddr), .awProt(prot),
        .wValid(wValid), .wReady(wReady),
        .wData(wData), .wStrb(wStrb),
        .bValid(bValid), .bReady(bReady), .bResp(bResp),
        .arValid(arValid), .arReady(arReady),
        .arAddr(arAddr), .arProt(prot),
        .rValid(rValid), .rReady(rReady),
        .rData(rData), .rResp(rResp)
    );

    axil_sram #(.DATA_W(64), .ADDR_W(32), .MEM_W(4)) dutWide (
        .aclk(aclk), .areset(areset),
        .awValid(xAwValid), .awReady(xAwReady),
        .awAddr(xAwAddr), .awProt(prot),
        .wValid(xWValid), .wReady(xWReady),
        .wData(xWData), .wStrb(xWStrb),
        .bValid(xBValid), .bReady(xBReady), .bResp(xBResp),
        .arValid(xArValid), .arReady(xArReady),
        .arAddr(xArAddr), .arProt(prot),
        .rValid(xRValid), .rReady(xRReady),
        .rData(xRData), .rResp(xRResp)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] merge32(
        input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] merge64(
        input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r = old;
        for (int i = 0; i < 8; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Beyond 1024 words (32-bit) or 16 words (64-bit) is out of range.
    function automatic bit oor32(input logic [31:0] a);
        return RC && ((a >> 12) != 0);
    endfunction

    function automatic bit oor64(input logic [31:0] a);
        return RC && ((a >> 7) != 0);
    endfunction

    function automatic logic [1:0] expResp(input bit bad);
        return bad ? 2'b10 : 2'b00;
    endfunction

    task automatic axWrite(input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] s, input int awDelay,
                           input int wDelay, output logic [1:0] resp,
                           output bit ok);
        bit awDone = 0, wDone = 0, hsA, hsW;
        int t = 0;
        ok = 0;
        resp = 2'b11;
        while (!(awDone && wDone) && t < 50) begin
            awValid = !awDone && (t >= awDelay);
            wValid  = !wDone && (t >= wDelay);
            awAddr  = addr;
            wData   = d;
            wStrb   = s;
            hsA = awValid && awReady;
            hsW = wValid && wReady;
            tick();
            awDone |= hsA;
            wDone  |= hsW;
            t++;
        end
        awValid = 0;
        wValid  = 0;
        if (awDone && wDone) begin
            if (!oor32(addr))
                refMem[addr[11:2]] = merge32(refMem[addr[11:2]], d, s);
            ok   = bValid;
            resp = bResp;
            bReady = 1;
            tick();
            bReady = 0;
        end
    endtask

    task automatic axRead(input logic [31:0] addr, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
        bit hs = 0;
        ok = 0;
        d = 32'hx;
        resp = 2'b11;
        for (int t = 0; t < 50 && !hs; t++) begin
            arValid = 1;
            arAddr  = addr;
            hs = arReady;
            tick();
        end
        arValid = 0;
        if (hs) begin
            ok   = rValid;
            d    = rData;
            resp = rResp;
            rReady = 1;
            tick();
            rReady = 0;
        end
    endtask

    task automatic xWrite(input logic [31:0] addr, input logic [63:0] d,
                          input logic [7:0] s, output logic [1:0] resp,
                          output bit ok);
        bit hs = 0;
        ok = 0;
        resp = 2'b11;
        for (int t = 0; t < 50 && !hs; t++) begin
            xAwValid = 1;
            xWValid  = 1;
            xAwAddr  = addr;
            xWData   = d;
            xWStrb   = s;
            hs = xAwReady && xWReady;
            tick();
        end
        xAwValid = 0;
        xWValid  = 0;
        if (hs) begin
            if (!oor64(addr))
                refWide[addr[6:3]] = merge64(refWide[addr[6:3]], d, s);
            ok   = xBValid;
            resp = xBResp;
            xBReady = 1;
            tick();
            xBReady = 0;
        end
    endtask

    task automatic xRead(input logic [31:0] addr, output logic [63:0] d,
                         output logic [1:0] resp, output bit ok);
        bit hs = 0;
        ok = 0;
        d = 64'hx;
        resp = 2'b11;
        for (int t = 0; t < 50 && !hs; t++) begin
            xArValid = 1;
            xArAddr  = addr;
            hs = xArReady;
            tick();
        end
        xArValid = 0;
        if (hs) begin
            ok   = xRValid;
            d    = xRData;
            resp = xRResp;
            xRReady = 1;
            tick();
            xRReady = 0;
        end
    endtask

    task automatic test_reset();
        areset = 1;
        tick();
        tick();
        checks++;
        if ({awReady, wReady, bValid, arReady, rValid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000",
                     {awReady, wReady, bValid, arReady, rValid});
        end
        checks++;
        if (rData !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h exp 0", rData);
        end
        checks++;
        if ({xAwReady, xWReady, xBValid, xArReady, xRValid, xRData} !== '0) begin
            errors++;
            $display("FAIL reset_wide got %b exp 0",
                     {xAwReady, xWReady, xBValid, xArReady, xRValid});
        end
        areset = 0;
        tick();
        checks++;
        if ({awReady, wReady, arReady, bValid, rValid} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_release got %b exp 11100",
                     {awReady, wReady, arReady, bValid, rValid});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp;
        logic [31:0] d;
        bit ok;
        axWrite(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_write got ok=%0d resp=%b exp ok=1 resp=00",
                     ok, resp);
        end
        axRead(32'h10, d, resp, ok);
        checks++;
        if (!ok || d !== refMem[4] || d !== 32'hDEADBEEF || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_read got ok=%0d %h/%b exp %h/00",
                     ok, d, resp, 32'hDEADBEEF);
        end
    endtask

    task automatic test_w_first();
        logic [1:0] resp;
        logic [31:0] d;
        bit ok;
        axWrite(32'h14, 32'hFFFFFFFF, 4'hF, 0, 0, resp, ok);
        axWrite(32'h14, 32'h11223344, 4'h5, 2, 0, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00) begin
            errors++;
            $display("FAIL wfirst_write got ok=%0d resp=%b exp ok=1 resp=00",
                     ok, resp);
        end
        axRead(32'h14, d, resp, ok);
        checks++;
        if (!ok || d !== 32'hFF22FF44 || d !== refMem[5]) begin
            errors++;
            $display("FAIL wfirst_read got %h exp ff22ff44", d);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp;
        logic [31:0] d, a, exp;
        bit ok;
        for (int i = 16; i < 32; i++)
            axWrite(i * 4, $urandom, 4'hF, 0, 0, resp, ok);
        for (int n = 0; n < 40; n++) begin
            a = (32'($urandom_range(16, 31)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                a = a | (32'($urandom_range(1, 15)) << 12);
            axWrite(a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), resp, ok);
            checks++;
            if (!ok || resp !== expResp(oor32(a))) begin
                errors++;
                $display("FAIL rand_write a=%h got ok=%0d resp=%b exp %b",
                         a, ok, resp, expResp(oor32(a)));
            end
            a = (32'($urandom_range(16, 31)) << 2);
            if ($urandom_range(0, 3) == 0)
                a = a | (32'($urandom_range(1, 15)) << 12);
            exp = oor32(a) ? 32'h0 : refMem[a[11:2]];
            axRead(a, d, resp, ok);
            checks++;
            if (!ok || d !== exp || resp !== expResp(oor32(a))) begin
                errors++;
                $display("FAIL rand_read a=%h got %h/%b exp %h/%b",
                         a, d, resp, exp, expResp(oor32(a)));
            end
        end
    endtask

    task automatic test_stall();
        logic [1:0] resp;
        logic [31:0] d, expR;
        bit ok;
        axWrite(32'h24, 32'hC0FFEE00, 4'hF, 0, 0, resp, ok);
        axWrite(32'h18, 32'h600D600D, 4'hF, 0, 0, resp, ok);
        expR = refMem[5];
        awValid = 1; awAddr = 32'h20; wValid = 1;
        wData = 32'h13572468; wStrb = 4'hF;
        arValid = 1; arAddr = 32'h14;
        bReady = 0; rReady = 0;
        tick();
        refMem[8] = 32'h13572468;
        awAddr = 32'h24; wData = 32'hFFFF0000; arAddr = 32'h18;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({bValid, rValid, awReady, wReady, arReady} !== 5'b11000) begin
                errors++;
                $display("FAIL stall_flags c=%0d got %b exp 11000", c,
                         {bValid, rValid, awReady, wReady, arReady});
            end
            checks++;
            if (rData !== expR || bResp !== 2'b00 || rResp !== 2'b00) begin
                errors++;
                $display("FAIL stall_data c=%0d got %h/%b/%b exp %h/00/00",
                         c, rData, bResp, rResp, expR);
            end
            tick();
        end
        awValid = 0; wValid = 0; arValid = 0;
        bReady = 1; rReady = 1;
        tick();
        bReady = 0; rReady = 0;
        checks++;
        if ({bValid, rValid, awReady, wReady, arReady} !== 5'b00111) begin
            errors++;
            $display("FAIL stall_release got %b exp 00111",
                     {bValid, rValid, awReady, wReady, arReady});
        end
        axRead(32'h24, d, resp, ok);
        checks++;
        if (!ok || d !== refMem[9]) begin
            errors++;
            $display("FAIL stall_no_second got %h exp %h", d, refMem[9]);
        end
        axRead(32'h20, d, resp, ok);
        checks++;
        if (!ok || d !== refMem[8]) begin
            errors++;
            $display("FAIL stall_first got %h exp %h", d, refMem[8]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        logic [31:0] d;
        bit ok;
        axWrite(32'h30, 32'h12345678, 4'hF, 0, 0, resp, ok);
        awValid = 1; awAddr = 32'h30;
        tick();
        awValid = 0;
        checks++;
        if ({awReady, wReady, bValid} !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_have_aw got %b exp 010",
                     {awReady, wReady, bValid});
        end
        areset = 1;
        tick();
        areset = 0;
        checks++;
        if ({awReady, wReady, arReady, bValid} !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_in_reset got %b exp 0000",
                     {awReady, wReady, arReady, bValid});
        end
        tick();
        checks++;
        if ({awReady, wReady, arReady, bValid} !== 4'b1110) begin
            errors++;
            $display("FAIL rstmid_readies got %b exp 1110",
                     {awReady, wReady, arReady, bValid});
        end
        wValid = 1; wData = 32'hBAD0BAD0; wStrb = 4'hF;
        tick();
        wValid = 0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bValid, awReady, wReady} !== 3'b010) begin
                errors++;
                $display("FAIL rstmid_no_commit c=%0d got %b exp 010", c,
                         {bValid, awReady, wReady});
            end
            tick();
        end
        awValid = 1; awAddr = 32'h34;
        tick();
        awValid = 0;
        refMem[13] = 32'hBAD0BAD0;
        checks++;
        if (bValid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_late_aw bValid got %b exp 1", bValid);
        end
        bReady = 1;
        tick();
        bReady = 0;
        axRead(32'h30, d, resp, ok);
        checks++;
        if (!ok || d !== refMem[12]) begin
            errors++;
            $display("FAIL rstmid_word got %h exp %h", d, refMem[12]);
        end
        axRead(32'h34, d, resp, ok);
        checks++;
        if (!ok || d !== refMem[13]) begin
            errors++;
            $display("FAIL rstmid_new_word got %h exp %h", d, refMem[13]);
        end
    endtask

    task automatic test_rbw();
        logic [1:0] resp;
        logic [31:0] d, expOld;
        bit ok;
        axWrite(32'hC, 32'hA5A5A5A5, 4'hF, 0, 0, resp, ok);
        expOld = refMem[3];
        awValid = 1; awAddr = 32'hC; wValid = 1;
        wData = 32'h5A5A5A5A; wStrb = 4'hF;
        arValid = 1; arAddr = 32'hC;
        tick();
        awValid = 0; wValid = 0; arValid = 0;
        refMem[3] = 32'h5A5A5A5A;
        checks++;
        if ({bValid, rValid} !== 2'b11 || rData !== expOld) begin
            errors++;
            $display("FAIL rbw_old got %b/%h exp 11/%h",
                     {bValid, rValid}, rData, expOld);
        end
        bReady = 1; rReady = 1;
        tick();
        bReady = 0; rReady = 0;
        axRead(32'hC, d, resp, ok);
        checks++;
        if (!ok || d !== refMem[3]) begin
            errors++;
            $display("FAIL rbw_new got %h exp %h", d, refMem[3]);
        end
    endtask

    task automatic test_wide();
        logic [1:0] resp;
        logic [63:0] d, exp;
        bit ok;
        for (int i = 0; i < 16; i++)
            xWrite(32'(i * 8), {$urandom, $urandom}, 8'hFF, resp, ok);
        xWrite(32'h80, 64'h0123456789ABCDEF, 8'hFF, resp, ok);
        checks++;
        if (!ok || resp !== expResp(oor64(32'h80))) begin
            errors++;
            $display("FAIL wide_write got ok=%0d resp=%b exp %b",
                     ok, resp, expResp(oor64(32'h80)));
        end
        for (int i = 0; i < 16; i++) begin
            xRead(32'(i * 8), d, resp, ok);
            checks++;
            if (!ok || d !== refWide[i] || resp !== 2'b00) begin
                errors++;
                $display("FAIL wide_word%0d got %h/%b exp %h/00",
                         i, d, resp, refWide[i]);
            end
        end
        exp = oor64(32'h80) ? 64'h0 : refWide[0];
        xRead(32'h80, d, resp, ok);
        checks++;
        if (!ok || d !== exp || resp !== expResp(oor64(32'h80))) begin
            errors++;
            $display("FAIL wide_read80 got %h/%b exp %h/%b",
                     d, resp, exp, expResp(oor64(32'h80)));
        end
    endtask

    initial begin
        prot = 3'b000;
        areset = 1;
        awValid = 0; wValid = 0; bReady = 0; arValid = 0; rReady = 0;
        awAddr = 0; wData = 0; wStrb = 0; arAddr = 0;
        xAwValid = 0; xWValid = 0; xBReady = 0; xArValid = 0; xRReady = 0;
        xAwAddr = 0; xWData = 0; xWStrb = 0; xArAddr = 0;
        test_reset();
        test_basic();
        test_w_first();
        test_random();
        test_stall();
        test_reset_mid();
        test_rbw();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
